alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter N, default 8, data width of B, C and result.
REQ-002 Parameter SETTLE_CYCLES, default 3, relay settle cycles; legal range 1..15.
REQ-003 clk  input  1  system clock, rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request one ALU operation; sampled only in IDLE.
REQ-006 op  input  3  function code, alu_op_t.
REQ-007 dest  input  1  0 = register A, 1 = register D.
REQ-008 b_in, c_in  input  N  operands from registers B and C.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 alu_result  output  N  registered result; feeds the A/D result registers.
REQ-011 load_a, load_d  output  1  one-cycle load strobes to the A/D result registers.
REQ-012 carry, zero, sign  output  1  registered condition flags.
REQ-013 done  output  1  one-cycle pulse, coincident with the load strobe.

Function
REQ-014 States SHALL be IDLE, SETTLE and STROBE; no other states.
REQ-015 IDLE with start=1: latch b_in, c_in, op and dest, then go to SETTLE.
REQ-016 SETTLE: hold for exactly SETTLE_CYCLES cycles via a down-counter, then go to STROBE.
REQ-017 STROBE, lasting one cycle:
- alu_result and flags updated from the latched operands
- done=1
- load_a=1 if dest=0, else load_d=1
- return to IDLE.
REQ-018 Latency: start accepted at edge t; the strobe is high during cycle t+1+SETTLE_CYCLES.
REQ-019 start while busy=1 SHALL be ignored; the latched operands are unaffected.
REQ-020 Operand changes after acceptance SHALL NOT affect the result.
REQ-021 Ops:
- 000 ADD b+c
- 001 INC b+1
- 010 AND
- 011 OR
- 100 XOR
- 101 NOT b
- 110 SHL: rotate b left by 1
- 111 CLR: result 0.
REQ-022 Result SHALL be truncated to N bits; carry = bit N of ADD/INC, 0 for all other ops.
REQ-023 zero = (result==0); sign = result[N-1].
REQ-024 alu_result and flags SHALL hold their last values outside STROBE.
REQ-025 load_a and load_d SHALL never be high together; neither is high outside STROBE.
REQ-026 start high in the same cycle as the STROBE→IDLE transition SHALL be ignored; start is sampled only while already in IDLE.

Reset
REQ-027 rst_n low, asynchronously:
- state IDLE, counter 0
- alu_result 0
- carry, zero, sign, busy, done, load_a, load_d all 0.
REQ-028 Reset mid-operation SHALL abort with no strobe; after release, the next start begins a fresh operation.

Configuration
REQ-029 Macro ALU_SETTLE_DELAY_EN defined: SETTLE state and counter present, per REQ-016.
REQ-030 Macro ALU_SETTLE_DELAY_EN undefined:
- SETTLE and counter omitted; IDLE goes directly to STROBE
- latency is strobe in cycle t+1
- SETTLE_CYCLES is ignored.

Structure
REQ-031 Package relay_pkg SHALL hold alu_op_t (3-bit enum, codes per REQ-021), the state enum and the default N.
REQ-032 Combinational function SHALL be sub-module alu_core:
- inputs: op, b, c
- outputs: result, carry
- instantiated once, fed from the latched operands.

Verification
REQ-033 Reset: rst_n=0 mid-SETTLE → all outputs 0, state IDLE, no load strobe, no done.
REQ-034 ADD, N=8, SETTLE_CYCLES=3: b=0xF0, c=0x20, dest=0 → result 0x10, carry=1, zero=0, sign=0, load_a high in cycle t+4 only.
REQ-035 INC with b=0xFF, dest=1 → result 0x00, carry=1, zero=1, load_d pulse; then SHL with b=0x81 → result 0x03, carry=0.
REQ-036 Busy handling: start pulsed every cycle with varying operands → only the first accepted, exactly one strobe, result uses first operands; start at the STROBE cycle ignored.
REQ-037 Config: build without ALU_SETTLE_DELAY_EN, AND 0xCC & 0xAA → result 0x88, sign=1, done in cycle t+1.
REQ-038 Sweep all 8 ops against a reference model with random operands (≥1000 ops); check flags, one-hot strobes and latency.

Source files
------------

// File: rtl/relay_pkg.sv
// Shared types for the relay ALU sequencer: op codes, FSM states and default width.
// ALU_SETTLE_DELAY_EN adds the SETTLE state to the state enum.
package relay_pkg;

  localparam int unsigned DefaultN = 8;

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpInc = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpXor = 3'b100,
    OpNot = 3'b101,
    OpShl = 3'b110,
    OpClr = 3'b111
  } alu_op_t;

`ifdef ALU_SETTLE_DELAY_EN
  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StSettle = 2'b01,
    StStrobe = 2'b10
  } state_t;
`else
  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StStrobe = 2'b10
  } state_t;
`endif

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU function: eight ops on b/c, carry only from ADD and INC.
module alu_core
  import relay_pkg::*;
#(
  parameter int unsigned N = DefaultN
) (
  input  logic [2:0]   op_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] c_i,
  output logic [N-1:0] result_o,
  output logic         carry_o
);

  logic [N:0] sum;

  always_comb begin
    sum      = '0;
    result_o = '0;
    carry_o  = 1'b0;
    case (alu_op_t'(op_i))
      OpAdd: begin
        sum      = {1'b0, b_i} + {1'b0, c_i};
        result_o = sum[N-1:0];
        carry_o  = sum[N];
      end
      OpInc: begin
        sum      = {1'b0, b_i} + (N+1)'(1);
        result_o = sum[N-1:0];
        carry_o  = sum[N];
      end
      OpAnd:   result_o = b_i & c_i;
      OpOr:    result_o = b_i | c_i;
      OpXor:   result_o = b_i ^ c_i;
      OpNot:   result_o = ~b_i;
      OpShl:   result_o = {b_i[N-2:0], b_i[N-1]};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Relay ALU sequencer: latch operands on start, optionally settle, then one-cycle strobe.
// ALU_SETTLE_DELAY_EN enables the SETTLE state and its down-counter.
module alu_sequencer
  import relay_pkg::*;
#(
  parameter int unsigned N             = DefaultN,
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [2:0]   op_i,
  input  logic         dest_i,
  input  logic [N-1:0] b_in_i,
  input  logic [N-1:0] c_in_i,
  output logic         busy_o,
  output logic [N-1:0] alu_result_o,
  output logic         load_a_o,
  output logic         load_d_o,
  output logic         carry_o,
  output logic         zero_o,
  output logic         sign_o,
  output logic         done_o
);

  state_t       state_q, state_d;
  logic [2:0]   op_q, op_d;
  logic         dest_q, dest_d;
  logic [N-1:0] b_q, b_d, c_q, c_d;
  logic [N-1:0] result_q, result_d;
  logic         carry_q, carry_d, zero_q, zero_d, sign_q, sign_d;
  logic [N-1:0] core_result;
  logic         core_carry;
  logic         accept;

  assign accept = (state_q == StIdle) && start_i;

  assign op_d   = accept ? op_i   : op_q;
  assign dest_d = accept ? dest_i : dest_q;
  assign b_d    = accept ? b_in_i : b_q;
  assign c_d    = accept ? c_in_i : c_q;

  // Core sees the operand registers' next value: equal to the latched operands when entering
  // STROBE from SETTLE, and the just-accepted operands when IDLE goes straight to STROBE.
  alu_core #(
    .N(N)
  ) u_alu_core (
    .op_i    (op_d),
    .b_i     (b_d),
    .c_i     (c_d),
    .result_o(core_result),
    .carry_o (core_carry)
  );

`ifdef ALU_SETTLE_DELAY_EN
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StSettle;
          cnt_d   = 4'(SETTLE_CYCLES - 1);
        end
      end
      StSettle: begin
        if (cnt_q == 4'd0) begin
          state_d = StStrobe;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StStrobe: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_settle;
  assign unused_settle = ^SETTLE_CYCLES;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_i) state_d = StStrobe;
      StStrobe: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end
`endif

  always_comb begin
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    sign_d   = sign_q;
    if (state_d == StStrobe) begin
      result_d = core_result;
      carry_d  = core_carry;
      zero_d   = (core_result == '0);
      sign_d   = core_result[N-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= 3'b000;
      dest_q   <= 1'b0;
      b_q      <= '0;
      c_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dest_q   <= dest_d;
      b_q      <= b_d;
      c_q      <= c_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      sign_q   <= sign_d;
    end
  end

  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StStrobe);
  assign load_a_o     = done_o & ~dest_q;
  assign load_d_o     = done_o & dest_q;
  assign alu_result_o = result_q;
  assign carry_o      = carry_q;
  assign zero_o       = zero_q;
  assign sign_o       = sign_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: random and directed ops against an arithmetic model.
module tb_alu_sequencer;

  localparam int N = 8;
  localparam int S = 3;
`ifdef ALU_SETTLE_DELAY_EN
  localparam int Lat = S;
`else
  localparam int Lat = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic         dest;
  logic [N-1:0] b_in, c_in;
  logic         busy, load_a, load_d, carry, zero, sign, done;
  logic [N-1:0] alu_result;

  alu_sequencer #(
    .N            (N),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .op_i        (op),
    .dest_i      (dest),
    .b_in_i      (b_in),
    .c_in_i      (c_in),
    .busy_o      (busy),
    .alu_result_o(alu_result),
    .load_a_o    (load_a),
    .load_d_o    (load_d),
    .carry_o     (carry),
    .zero_o      (zero),
    .sign_o      (sign),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res;
    bit cy;
    bit zr;
    bit sg;
    bit dst;
    int edge_no;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   edge_n     = 0;
  int   idle_from  = 0;
  int   accepted   = 0;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Result computed from plain integer arithmetic on the op definitions.
  function automatic void ref_op(input int o, input int b, input int c,
                                 output int res, output bit cy);
    int mask = (1 << N) - 1;
    int s;
    case (o)
      0:       s = b + c;
      1:       s = b + 1;
      2:       s = b & c;
      3:       s = b | c;
      4:       s = b ^ c;
      5:       s = ~b & mask;
      6:       s = ((b * 2) + (b / (1 << (N - 1)))) & mask;
      default: s = 0;
    endcase
    res = s & mask;
    cy  = (o == 0 || o == 1) && (s > mask);
  endfunction

  // Model of acceptance: start is taken only once the previous strobe has returned to idle.
  always @(posedge clk) begin
    exp_t e;
    edge_n++;
    if (rst_n && start && edge_n >= idle_from) begin
      ref_op(int'(op), int'(b_in), int'(c_in), e.res, e.cy);
      e.zr      = (e.res == 0);
      e.sg      = ((e.res >> (N - 1)) & 1) != 0;
      e.dst     = dest;
      e.edge_no = edge_n + Lat;
      q.push_back(e);
      idle_from = edge_n + Lat + 2;
      accepted++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("busy", int'(busy), int'(edge_n + 1 < idle_from));
      chk("strobe_onehot", int'({load_a, load_d, done}),
          done ? (load_a ? 3'b101 : 3'b011) : 3'b000);
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("latency_edge", edge_n, e.edge_no);
          chk("result", int'(alu_result), e.res);
          chk("flags_czs", int'({carry, zero, sign}), int'({e.cy, e.zr, e.sg}));
          chk("load_ad", int'({load_a, load_d}), e.dst ? 2 'b01 : 2'b10);
        end
      end else if (q.size() != 0 && edge_n > q[0].edge_no) begin
        chk("missing_strobe", 0, 1);
        void'(q.pop_front());
      end
    end
  end

  task automatic issue(input int o, input int b, input int c, input bit d);
    int waited = 0;
    @(negedge clk);
    while (edge_n + 1 < idle_from && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) chk("issue_timeout", 1, 0);
    start = 1'b1;
    op    = 3'(o);
    b_in  = N'(b);
    c_in  = N'(c);
    dest  = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    chk(name, int'({alu_result, carry, zero, sign, busy, done, load_a, load_d}), 0);
  endtask

  initial begin
    int waited;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    dest  = 1'b0;
    b_in  = '0;
    c_in  = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;

    issue(0, 'hF0, 'h20, 1'b0);
    issue(1, 'hFF, 'h00, 1'b1);
    issue(6, 'h81, 'h00, 1'b0);
    issue(2, 'hCC, 'hAA, 1'b0);
    issue(7, 'h5A, 'hA5, 1'b1);

    // Abort an operation with an asynchronous reset before it strobes.
    issue(3, 'h12, 'h34, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid_op");
    q.delete();
    idle_from = 0;
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs("reset_held");
    end
    rst_n = 1'b1;
    issue(4, 'h3C, 'h0F, 1'b0);

    // Start held high with changing operands: only idle-time starts are accepted.
    @(negedge clk);
    repeat (24) begin
      start = 1'b1;
      op    = 3'($urandom_range(0, 7));
      b_in  = N'($urandom);
      c_in  = N'($urandom);
      dest  = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;

    accepted = 0;
    while (accepted < 1100 && edge_n < 40000) begin
      start = ($urandom_range(0, 3) != 0);
      op    = 3'($urandom_range(0, 7));
      b_in  = N'($urandom);
      c_in  = N'($urandom);
      dest  = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    chk("random_ops_issued", int'(accepted >= 1000), 1);

    waited = 0;
    while (q.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
